// File: rtl/lane_select_pipe.sv
// Lane select into a 2-entry output FIFO: picks one lane from each bank.
// Define LANE_SELECT_PIPE_ROTATE_EN to advance the lane pointer per accepted input.
module lane_select_pipe #(
   parameter int W         = 4,
   parameter int NLANES    = 10,
   parameter int BASE_LANE = 0,
   parameter int LW        = $clog2(NLANES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NLANES*W-1:0] in_a,
   input  logic [NLANES*W-1:0] in_b,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [2*W-1:0]    out_data,
   output logic [LW-1:0]     out_lane,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam logic [LW-1:0] BASE_L = LW'(BASE_LANE);
   localparam logic [LW-1:0] LAST_L = LW'(NLANES - 1);

   logic [LW-1:0]  ptr;
   logic [1:0]     count;
   logic           wr_i;
   logic           rd_i;
   logic [2*W-1:0] mem_d [2];
   logic [LW-1:0]  mem_l [2];
   logic [W-1:0]   sel_a;
   logic [W-1:0]   sel_b;
   logic           push;
   logic           pop;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NLANES; k++) begin
         if (ptr == LW'(k)) begin
            sel_a = in_a[k*W +: W];
            sel_b = in_b[k*W +: W];
         end
      end
   end

   // in_ready depends only on stored count, never on out_ready
   assign in_ready  = rst_n && (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem_d[rd_i] : '0;
   assign out_lane  = out_valid ? mem_l[rd_i] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= 2'd0;
         wr_i     <= 1'b0;
         rd_i     <= 1'b0;
         mem_d[0] <= '0;
         mem_d[1] <= '0;
         mem_l[0] <= '0;
         mem_l[1] <= '0;
      end else begin
         if (push) begin
            mem_d[wr_i] <= {sel_b, sel_a};
            mem_l[wr_i] <= ptr;
            wr_i        <= ~wr_i;
         end
         if (pop) begin
            rd_i <= ~rd_i;
         end
         if (push && !pop) begin
            count <= count + 2'd1;
         end else if (!push && pop) begin
            count <= count - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= BASE_L;
`ifdef LANE_SELECT_PIPE_ROTATE_EN
      end else if (push) begin
         ptr <= (ptr == LAST_L) ? '0 : ptr + 1'b1;
`else
      end else begin
         ptr <= BASE_L;
`endif
      end
   end

endmodule

// File: tb/tb_lane_select_pipe.sv
// Randomized bench for lane_select_pipe against a queue-based model.
// Model rotation follows LANE_SELECT_PIPE_ROTATE_EN like the design.
module tb_lane_select_pipe;

   localparam int W      = 4;
   localparam int NLANES = 10;
   localparam int BASE   = 0;
   localparam int LW     = $clog2(NLANES);

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NLANES*W-1:0] in_a;
   logic [NLANES*W-1:0] in_b;
   logic              in_valid;
   logic              in_ready;
   logic [2*W-1:0]    out_data;
   logic [LW-1:0]     out_lane;
   logic              out_valid;
   logic              out_ready;

   int errs = 0;
   int checks = 0;

   logic [2*W-1:0] qd [$];
   logic [LW-1:0]  ql [$];
   int             mptr;

   lane_select_pipe #(
      .W(W), .NLANES(NLANES), .BASE_LANE(BASE)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_a(in_a), .in_b(in_b),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_lane(out_lane),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] lane_of(input logic [NLANES*W-1:0] bank,
                                            input int idx);
      logic [NLANES*W-1:0] t;
      t = bank >> (idx * W);
      return t[W-1:0];
   endfunction

   task automatic check_outs();
      int n;
      n = qd.size();
      chk("out_valid", 32'(out_valid), 32'(n != 0));
      chk("in_ready", 32'(in_ready), 32'(n < 2));
      chk("out_data", 32'(out_data), (n != 0) ? 32'(qd[0]) : 32'd0);
      chk("out_lane", 32'(out_lane), (n != 0) ? 32'(ql[0]) : 32'd0);
   endtask

   task automatic tick();
      bit acc;
      bit pp;
      @(negedge clk);
      check_outs();
      @(posedge clk);
      acc = in_valid && (qd.size() < 2);
      pp  = out_ready && (qd.size() > 0);
      if (pp) begin
         void'(qd.pop_front());
         void'(ql.pop_front());
      end
      if (acc) begin
         qd.push_back({lane_of(in_b, mptr), lane_of(in_a, mptr)});
         ql.push_back(LW'(mptr));
`ifdef LANE_SELECT_PIPE_ROTATE_EN
         mptr = (mptr + 1) % NLANES;
`endif
      end
      #1;
   endtask

   task automatic rand_banks();
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
   endtask

   initial begin
      int exp_lane;
      rst_n = 1'b0;
      in_a = '0;
      in_b = '0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      mptr = BASE;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_lane", 32'(out_lane), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // lane k of A holds k, lane k of B holds 15-k
      for (int k = 0; k < NLANES; k++) begin
         in_a[k*W +: W] = W'(k);
         in_b[k*W +: W] = W'(15 - k);
      end
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("first_valid", 32'(out_valid), 32'd1);
      chk("first_data", 32'(out_data), 32'hF0);
      chk("first_lane", 32'(out_lane), 32'd0);
      tick();
      tick();

      // stall: three offers, only two fit, head frozen
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_banks();
         tick();
      end
      chk("full_in_ready", 32'(in_ready), 32'd0);

      // full with both sides active: pop now, push next
      out_ready = 1'b1;
      rand_banks();
      tick();
      out_ready = 1'b0;
      rand_banks();
      tick();
      chk("refill_full", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      tick();

      // advance pointer, fill, then reset mid-operation
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         rand_banks();
         tick();
      end
      out_ready = 1'b0;
      rand_banks();
      tick();
      rand_banks();
      tick();
      tick();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      chk("mid_rst_lane", 32'(out_lane), 32'd0);
      qd.delete();
      ql.delete();
      mptr = BASE;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // back-to-back transfers from reset pointer
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         rand_banks();
         tick();
`ifdef LANE_SELECT_PIPE_ROTATE_EN
         exp_lane = i % NLANES;
`else
         exp_lane = BASE;
`endif
         chk("b2b_lane", 32'(out_lane), 32'(exp_lane));
         chk("b2b_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      tick();

      for (int i = 0; i < 400; i++) begin
         rand_banks();
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
